key_expansion_ctrl: RTL and testbench
=====================================

KEY_EXPANSION_CTRL -- requirements
Module: key_expansion_ctrl

Interface
REQ-001 Parameter n, default 32: word size in bits.
REQ-002 Parameter m, default 3: number of master-key words.
REQ-003 Parameter T, default 42: number of round keys, indexed 0..T-1.
REQ-004 Parameter Z, default z_2 (62 bits): bit j holds sequence symbol z_2[j].
REQ-005 clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  request to expand key_in; sampled on each rising edge.
REQ-008 key_in  input  m*n  master key: [n-1:0]=k0, [2n-1:n]=k1, [3n-1:2n]=k2.
REQ-009 busy  output  1  high while expansion is in progress.
REQ-010 done  output  1  one-cycle pulse when key T-1 is written.
REQ-011 ready  output  1  level; high when all T round keys are valid.
REQ-012 rk_rd_addr  input  6  round-key read index.
REQ-013 rk_rd_data  output  n  registered read data.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, EXPAND and DONE.
REQ-015 In IDLE or DONE with start=1, the block SHALL write k0..k2 to mem[0..2] and load window registers w3=k0, w2=k1, w1=k2 on the same edge, set i=3 and enter EXPAND.
REQ-016 Each EXPAND cycle SHALL compute k[i] = C ^ Z[(i-3) mod 62] ^ w3 ^ ror(w1,3) ^ ror(w1,4), where C = 2^n-4 (0xFFFFFFFC) and the Z bit is zero-extended.
REQ-017 Each EXPAND cycle SHALL write k[i] to mem[i], shift the window (w3<=w2, w2<=w1, w1<=k[i]) and increment i; no memory read feeds the recurrence.
REQ-018 The i counter SHALL be 6 bits wide; the z index SHALL be i-3 (it does not exceed 38 for T=42, and modulo-62 wrap is specified for generality).
REQ-019 On the edge that writes k[T-1], the FSM SHALL enter DONE and assert done for exactly the following cycle.
REQ-020 With T=42, k[3]..k[41] SHALL take 39 EXPAND cycles, so done is high in the 39th cycle after the start edge.
REQ-021 busy SHALL be high exactly while the state is EXPAND.
REQ-022 ready SHALL be high exactly while the state is DONE.
REQ-023 start during EXPAND SHALL be ignored, with no effect on state, i or memory.
REQ-024 start in DONE SHALL restart the expansion: ready falls on the start edge and the old keys are overwritten.
REQ-025 rk_rd_data SHALL equal mem[rk_rd_addr] with a one-cycle latency, in any state.
REQ-026 rk_rd_data SHALL be 0 when rk_rd_addr >= T.
REQ-027 A read of the same address on the cycle it is written SHALL return the old value.
REQ-028 Contents read while ready=0 are unspecified.

Reset
REQ-029 On rst=1 at an edge, the block SHALL set state=IDLE, i=0, window registers=0, busy=0, done=0, ready=0 and rk_rd_data=0.
REQ-030 rst SHALL take priority over start and over any in-progress expansion.
REQ-031 The memory SHALL NOT be cleared by reset.
REQ-032 Reset mid-EXPAND SHALL abort cleanly; the next start SHALL yield a complete, correct key set.

Verification
REQ-033 Key k2,k1,k0 = 0x13121110, 0x0b0a0908, 0x03020100, then start -> after done, reads of addresses 0..3 return 0x03020100, 0x0b0a0908, 0x13121110, 0xFFAE9DCE.
REQ-034 All-zero key, then start -> mem[3]=0xFFFFFFFD and mem[4]=0x9FFFFFFC; done is high exactly one cycle, 39 cycles after the start edge; busy is high for 39 cycles.
REQ-035 Hold start=1 continuously throughout EXPAND -> one expansion only; done pulses once; then an immediate restart occurs from DONE.
REQ-036 rst asserted at i=20, then start with the REQ-033 key -> keys 0..41 match the golden model and ready is high only after the new done.
REQ-037 Read address 42 and address 63 in DONE -> rk_rd_data = 0.
REQ-038 Read back all 42 keys in DONE and compare against a software SIMON64/96 key schedule -> all 42 words match.

Source files
------------

// File: rtl/key_expansion_ctrl.sv
// SIMON-style round-key expansion controller: loads a 3-word master key, expands
// T round keys one per cycle into a key memory, and serves registered reads.
module key_expansion_ctrl #(
  parameter int          n = 32,
  parameter int          m = 3,
  parameter int          T = 42,
  parameter logic [61:0] Z = 62'h3369F885192C0EF5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [m*n-1:0] key_in,
  output logic           busy,
  output logic           done,
  output logic           ready,
  input  logic [5:0]     rk_rd_addr,
  output logic [n-1:0]   rk_rd_data
);

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  localparam logic [n-1:0] C      = {{(n-2){1'b1}}, 2'b00};
  localparam logic [5:0]   LAST_I = 6'(T - 1);
  localparam logic [6:0]   T_W    = 7'(T);

  state_t         state_reg;
  logic [5:0]     i_reg;
  logic [n-1:0]   w1_reg;
  logic [n-1:0]   w2_reg;
  logic [n-1:0]   w3_reg;
  logic [n-1:0]   mem [0:T-1];
  logic [n-1:0]   k_next;
  logic [5:0]     z_idx;
  logic           load;
  logic           expanding;

  function automatic logic [n-1:0] ror(input logic [n-1:0] x, input int s);
    return (x >> s) | (x << (n - s));
  endfunction

  assign load      = start && (state_reg != EXPAND);
  assign expanding = (state_reg == EXPAND);

  // The recurrence only ever looks at the three-word window, never at memory.
  always_comb begin
    z_idx = i_reg - 6'd3;
    if (z_idx >= 6'd62) begin
      z_idx = z_idx - 6'd62;
    end
    k_next = C ^ {{(n-1){1'b0}}, Z[z_idx]} ^ w3_reg ^ ror(w1_reg, 3) ^ ror(w1_reg, 4);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      i_reg     <= 6'd0;
      w1_reg    <= '0;
      w2_reg    <= '0;
      w3_reg    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ready     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            w3_reg    <= key_in[0 +: n];
            w2_reg    <= key_in[n +: n];
            w1_reg    <= key_in[2*n +: n];
            i_reg     <= 6'd3;
            state_reg <= EXPAND;
            busy      <= 1'b1;
            ready     <= 1'b0;
          end
        end
        EXPAND: begin
          w3_reg <= w2_reg;
          w2_reg <= w1_reg;
          w1_reg <= k_next;
          i_reg  <= i_reg + 6'd1;
          if (i_reg == LAST_I) begin
            state_reg <= DONE;
            busy      <= 1'b0;
            ready     <= 1'b1;
            done      <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          ready     <= 1'b0;
        end
      endcase
    end
  end

  // Key storage keeps its contents across reset; reset only blocks writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (load) begin
        mem[0] <= key_in[0 +: n];
        mem[1] <= key_in[n +: n];
        mem[2] <= key_in[2*n +: n];
      end else if (expanding) begin
        mem[i_reg] <= k_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rk_rd_data <= '0;
    end else if ({1'b0, rk_rd_addr} < T_W) begin
      rk_rd_data <= mem[rk_rd_addr];
    end else begin
      rk_rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_key_expansion_ctrl.sv
// Scoreboard bench for key_expansion_ctrl: a software SIMON64/96 key schedule and a
// cycle-count control model feed expectations; a negedge monitor compares.
module tb_key_expansion_ctrl;
  localparam int T = 42;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [95:0] key_in = '0;
  logic        busy, done, ready;
  logic [5:0]  rk_rd_addr = '0;
  logic [31:0] rk_rd_data;

  always #5 clk = ~clk;

  key_expansion_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key_in     (key_in),
    .busy       (busy),
    .done       (done),
    .ready      (ready),
    .rk_rd_addr (rk_rd_addr),
    .rk_rd_data (rk_rd_data)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int last_done_cyc = -1;
  int start_cyc = 0;

  logic [31:0] gold [T];
  logic [31:0] exp_q [$];
  logic [5:0]  addr_q [$];
  logic        rd_req = 1'b0;
  logic        rd_pend = 1'b0;

  logic m_busy = 1'b0, m_ready = 1'b0, m_done = 1'b0;
  int   m_left = 0;

  string z2 = "10101111011100000011010010011000101000010001111110010110110011";

  function automatic logic [31:0] rotr(input logic [31:0] x, input int s);
    return (x >> s) | (x << (32 - s));
  endfunction

  // Textbook SIMON64/96 schedule: k[i] = ~k[i-3] ^ tmp ^ (tmp>>>1) ^ z ^ 3.
  task automatic compute_gold(input logic [95:0] key);
    logic [31:0] tmp;
    for (int j = 0; j < 3; j++) gold[j] = key[32*j +: 32];
    for (int j = 3; j < T; j++) begin
      tmp = rotr(gold[j-1], 3);
      tmp = tmp ^ rotr(tmp, 1);
      gold[j] = ~gold[j-3] ^ tmp ^ 32'(z2[(j-3) % 62] == 8'h31) ^ 32'd3;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, got, expv);
    end
  endtask

  // Control model: a start outside an expansion begins a T-3 cycle countdown.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_pend <= rd_req;
    if (rst) begin
      m_busy <= 1'b0; m_ready <= 1'b0; m_done <= 1'b0; m_left <= 0;
    end else if (start && !m_busy) begin
      m_busy <= 1'b1; m_ready <= 1'b0; m_done <= 1'b0; m_left <= T - 3;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      m_done <= (m_left == 1);
      if (m_left == 1) begin
        m_busy  <= 1'b0;
        m_ready <= 1'b1;
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    logic [31:0] e;
    logic [5:0]  a;
    check("busy", {31'b0, busy}, {31'b0, m_busy});
    check("ready", {31'b0, ready}, {31'b0, m_ready});
    check("done", {31'b0, done}, {31'b0, m_done});
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        check("rd_no_expectation", rk_rd_data, 32'hDEADBEEF);
      end else begin
        e = exp_q.pop_front();
        a = addr_q.pop_front();
        check($sformatf("rd_data@%0d", a), rk_rd_data, e);
        $display("[TB] read addr=%0d data=%08h expected=%08h", a, rk_rd_data, e);
      end
    end
  end

  task automatic rd(input logic [5:0] a, input logic [31:0] e);
    @(negedge clk);
    rk_rd_addr = a;
    rd_req = 1'b1;
    exp_q.push_back(e);
    addr_q.push_back(a);
  endtask

  task automatic rd_idle();
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic rd_all();
    for (int a = 0; a < T; a++) rd(6'(a), gold[a]);
    rd_idle();
  endtask

  task automatic do_start(input logic [95:0] key);
    @(negedge clk);
    key_in = key;
    start = 1'b1;
    start_cyc = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    compute_gold(key);
    $display("[TB] start key=%024h", key);
  endtask

  task automatic wait_ready(input int maxc);
    int k;
    k = 0;
    while (ready !== 1'b1 && k < maxc) begin
      @(negedge clk);
      k++;
    end
    check("ready_timeout", {31'b0, ready}, 32'd1);
    @(negedge clk);
  endtask

  localparam logic [95:0] KEY_A = {32'h13121110, 32'h0b0a0908, 32'h03020100};

  initial begin
    logic [95:0] k;
    int busy_base;
    int done_base;
    int seen;

    repeat (3) @(negedge clk);
    check("rst_rd_data", rk_rd_data, 32'd0);
    rst = 1'b0;

    // Reference key and out-of-range reads
    do_start(KEY_A);
    wait_ready(100);
    rd(0, 32'h03020100); rd(1, 32'h0b0a0908); rd(2, 32'h13121110); rd(3, 32'hFFAE9DCE);
    rd(42, 32'd0); rd(63, 32'd0);
    rd_idle();
    rd_all();

    // Restart from DONE with a same-edge read of word 0 (old value), all-zero key
    @(negedge clk);
    key_in = '0;
    start = 1'b1;
    start_cyc = cyc + 1;
    busy_base = busy_cnt;
    rk_rd_addr = 6'd0;
    rd_req = 1'b1;
    exp_q.push_back(gold[0]);
    addr_q.push_back(6'd0);
    @(negedge clk);
    start = 1'b0;
    rd_req = 1'b0;
    compute_gold('0);
    wait_ready(100);
    check("done_latency", 32'(last_done_cyc - start_cyc), 32'd39);
    check("busy_cycles", 32'(busy_cnt - busy_base), 32'd39);
    rd(3, 32'hFFFFFFFD); rd(4, 32'h9FFFFFFC);
    rd_idle();

    // start held high across a whole expansion
    k = {$urandom, $urandom, $urandom};
    @(negedge clk);
    key_in = k;
    start = 1'b1;
    done_base = done_cnt;
    seen = 0;
    for (int c = 0; c < 100 && seen == 0; c++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    check("held_done_seen", 32'(seen), 32'd1);
    @(negedge clk);
    check("held_done_pulses", 32'(done_cnt - done_base), 32'd1);
    check("held_restart_busy", {31'b0, busy}, 32'd1);
    start = 1'b0;
    compute_gold(k);
    wait_ready(100);
    rd_all();

    // Reset part-way through (i = 20), then a clean expansion
    do_start({$urandom, $urandom, $urandom});
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready_low", {31'b0, ready}, 32'd0);
    do_start(KEY_A);
    wait_ready(100);
    rd_all();

    // Random keys with random reads, in and out of range
    for (int r = 0; r < 4; r++) begin
      do_start({$urandom, $urandom, $urandom});
      wait_ready(100);
      for (int q = 0; q < 12; q++) begin
        int a;
        a = $urandom_range(0, 63);
        rd(6'(a), (a < T) ? gold[a] : 32'd0);
      end
      rd_idle();
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
